// File: rtl/dmem_lsu.sv
// dmem_lsu: data memory with load/store unit, registered reads, wait states and clear-after-reset
module dmem_lsu #(
    parameter int XLEN = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT_CYCLES = 0,
    localparam int BW = $clog2(XLEN / 8),
    localparam int ADDR_W = DEPTH_LOG2 + BW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_mode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              busy
);
    localparam int NB = XLEN / 8;

    typedef enum logic [2:0] {CLEAR, IDLE, WAIT, ACCESS, RESP} state_t;

    state_t state, state_n;
    logic [XLEN-1:0] mem [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;
    logic [3:0] cnt;
    logic r_we;
    logic [2:0] r_mode;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [BW-1:0] lane;
    logic [1:0] sz;
    logic [6:0] nbits;
    logic [XLEN-1:0] word, sh, m, v, ld_val, wsh;
    logic [NB-1:0] be;
    logic mis, ill, err, sgn;

    // decode the captured request: alignment/legality, load extraction with extension, store lanes
    always_comb begin
        sz = r_mode[1:0];
        lane = r_addr[BW-1:0];
        word = mem[r_addr[ADDR_W-1:BW]];
        sh = word >> {lane, 3'b000};
        nbits = 7'd8 << sz;
        m = (XLEN'(1) << nbits) - XLEN'(1);
        v = sh & m;
        sgn = !r_mode[2] && |(v & ~(m >> 1));
        ld_val = sgn ? (v | ~m) : v;
        wsh = r_wdata << {lane, 3'b000};
        be = NB'((NB'(1) << (4'd1 << sz)) - NB'(1)) << lane;
        mis = |(lane & BW'((4'd1 << sz) - 4'd1));
        ill = r_we ? (r_mode[2] || (XLEN == 32 && sz == 2'd3))
                   : (r_mode == 3'b111 || (XLEN == 32 && (r_mode == 3'b011 || r_mode == 3'b110)));
        err = mis || ill;
    end

    // next-state and handshake outputs
    always_comb begin
        state_n = state;
        req_ready = state == IDLE;
        resp_valid = state == RESP;
        busy = state != IDLE;
        case (state)
            CLEAR:   state_n = &idx ? IDLE : CLEAR;
            IDLE:    state_n = req_valid ? (WAIT_CYCLES > 0 ? WAIT : ACCESS) : IDLE;
            WAIT:    state_n = cnt == 4'd1 ? ACCESS : WAIT;
            ACCESS:  state_n = RESP;
            default: state_n = IDLE;
        endcase
    end

    // state, clear index, request capture, wait counter and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            idx <= '0;
            cnt <= '0;
            resp_rdata <= '0;
            resp_err <= 1'b0;
        end else begin
            state <= state_n;
            if (state == CLEAR) idx <= idx + 1'b1;
            if (state == IDLE && req_valid) begin
                r_we <= req_we;
                r_mode <= req_mode;
                r_addr <= req_addr;
                r_wdata <= req_wdata;
                cnt <= 4'(WAIT_CYCLES);
            end
            if (state == WAIT) cnt <= cnt - 1'b1;
            if (state == ACCESS) begin
                resp_err <= err;
                resp_rdata <= (err || r_we) ? '0 : ld_val;
            end
        end
    end

    // memory write port: clear sweep or byte-enabled store; nothing is written while rst is high
    always_ff @(posedge clk) begin
        if (!rst && state == CLEAR)
            mem[idx] <= '0;
        else if (!rst && state == ACCESS && r_we && !err)
            for (int b = 0; b < NB; b++)
                if (be[b]) mem[r_addr[ADDR_W-1:BW]][8*b +: 8] <= wsh[8*b +: 8];
    end
endmodule
